// File: rtl/mem_io_bridge_if.sv
// Processor-side memory bus between the CPU and mem_io_bridge.
// ADDR/DOUT/W come from the processor and DIN is returned to it.
//   master : processor view (drives ADDR, DOUT, W; receives DIN)
//   slave  : memory/IO view (receives ADDR, DOUT, W; drives DIN)
interface mem_io_bridge_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/mem_io_bridge.sv
// Memory and I/O subsystem behind the processor bus.
// ADDR[15:12] selects the region: 0 RAM, 1 LEDR, 2 HEX, 3 switches, 4 timer.
// All reads return one cycle after the address is sampled, in
// read-before-write order.
// Ports:
//   Clock, Resetn : clock, asynchronous active-low reset
//   bus           : ADDR/DOUT/W in, DIN out (mem_io_bridge_if.slave)
//   SW            : asynchronous switch inputs
//   LEDR, HEX     : LED and hex-display registers
//   Tick          : one-cycle pulse when the interval timer expires
module mem_io_bridge #(
  parameter int unsigned RAM_AW    = 7,
  parameter string       INIT_FILE = ""
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  mem_io_bridge_if.slave         bus,
  input  logic [8:0]             SW,
  output logic [8:0]             LEDR,
  output logic [15:0]            HEX,
  output logic                   Tick
);

  localparam int unsigned DW        = 16;
  localparam int unsigned SWW       = 9;
  localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

  localparam logic [3:0] REG_RAM   = 4'h0;
  localparam logic [3:0] REG_LED   = 4'h1;
  localparam logic [3:0] REG_HEX   = 4'h2;
  localparam logic [3:0] REG_SW    = 4'h3;
  localparam logic [3:0] REG_TIMER = 4'h4;

  localparam logic [1:0] TMR_COUNT  = 2'd0;
  localparam logic [1:0] TMR_PERIOD = 2'd1;
  localparam logic [1:0] TMR_STATUS = 2'd2;
  localparam logic [1:0] TMR_CTRL   = 2'd3;

  localparam bit HAS_INIT = (INIT_FILE != "");

  // Address decode
  logic [3:0]        region_c;
  logic [1:0]        tsel_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic              sel_ram_c;
  logic              sel_timer_c;

  assign region_c    = bus.ADDR[15:12];
  assign tsel_c      = bus.ADDR[1:0];
  assign ram_idx_c   = bus.ADDR[RAM_AW-1:0];
  assign sel_ram_c   = (region_c == REG_RAM);
  assign sel_timer_c = (region_c == REG_TIMER);

  // Address bits not used by any decode (aliasing inside a region)
  logic unused_addr_c;
  assign unused_addr_c = (^bus.ADDR[11:0]) ^ HAS_INIT;

  // Write strobes
  logic wr_led_c, wr_hex_c, wr_count_c, wr_period_c, wr_ctrl_c, clr_status_c;
  assign wr_led_c     = bus.W && (region_c == REG_LED);
  assign wr_hex_c     = bus.W && (region_c == REG_HEX);
  assign wr_count_c   = bus.W && sel_timer_c && (tsel_c == TMR_COUNT);
  assign wr_period_c  = bus.W && sel_timer_c && (tsel_c == TMR_PERIOD);
  assign wr_ctrl_c    = bus.W && sel_timer_c && (tsel_c == TMR_CTRL);
  assign clr_status_c = bus.W && sel_timer_c && (tsel_c == TMR_STATUS) && bus.DOUT[0];

  // ---------------------------------------------------------------------
  // Word RAM: synchronous single port, registered output, never reset.
  // ---------------------------------------------------------------------
  logic [DW-1:0] mem [RAM_DEPTH];
  logic [DW-1:0] ram_q;
  logic          ram_we_c;

  // Writes are blocked while reset is held so an aborted access cannot land.
  assign ram_we_c = bus.W && sel_ram_c && Resetn;

  always_ff @(posedge Clock) begin : ram_port
    if (ram_we_c) mem[ram_idx_c] <= bus.DOUT;
    ram_q <= mem[ram_idx_c];
  end

  // ---------------------------------------------------------------------
  // Switch synchronizer
  // ---------------------------------------------------------------------
  logic [SWW-1:0] sw_m;
  logic [SWW-1:0] sw_s;

  always_ff @(posedge Clock or negedge Resetn) begin : sw_sync
    if (!Resetn) begin
      sw_m <= '0;
      sw_s <= '0;
    end else begin
      sw_m <= SW;
      sw_s <= sw_m;
    end
  end

  // ---------------------------------------------------------------------
  // LED and hex display registers
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin : out_regs
    if (!Resetn) begin
      LEDR <= '0;
      HEX  <= '0;
    end else begin
      if (wr_led_c) LEDR <= bus.DOUT[SWW-1:0];
      if (wr_hex_c) HEX  <= bus.DOUT;
    end
  end

  // ---------------------------------------------------------------------
  // Interval timer
  // ---------------------------------------------------------------------
  logic [DW-1:0] count;
  logic [DW-1:0] period;
  logic          expired;
  logic          enable;
  logic          expire_c;

  // A software COUNT write suppresses the expiry on the same edge.
  assign expire_c = enable && !wr_count_c && (count == period);

  always_ff @(posedge Clock or negedge Resetn) begin : timer
    if (!Resetn) begin
      count   <= '0;
      period  <= '0;
      expired <= 1'b0;
      enable  <= 1'b0;
      Tick    <= 1'b0;
    end else begin
      Tick <= expire_c;
      if (wr_period_c) period <= bus.DOUT;
      if (wr_ctrl_c)   enable <= bus.DOUT[0];
      if (wr_count_c) begin
        count <= bus.DOUT;
      end else if (enable) begin
        if (expire_c) count <= '0;
        else          count <= count + DW'(1);
      end
      // Hardware set beats a software clear on the same edge.
      if (expire_c)          expired <= 1'b1;
      else if (clr_status_c) expired <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read path: register-side data and RAM-select are captured on the same
  // edge as the RAM output, so DIN selects between two registered sources.
  // ---------------------------------------------------------------------
  logic [DW-1:0] reg_rdata_c;
  logic [DW-1:0] reg_rdata_q;
  logic          sel_ram_q;

  always_comb begin : reg_read_mux
    reg_rdata_c = '0;
    unique case (region_c)
      REG_LED: reg_rdata_c = DW'(LEDR);
      REG_HEX: reg_rdata_c = HEX;
      REG_SW:  reg_rdata_c = DW'(sw_s);
      REG_TIMER: begin
        unique case (tsel_c)
          TMR_COUNT:  reg_rdata_c = count;
          TMR_PERIOD: reg_rdata_c = period;
          TMR_STATUS: reg_rdata_c = DW'(expired);
          TMR_CTRL:   reg_rdata_c = DW'(enable);
          default:    reg_rdata_c = '0;
        endcase
      end
      default: reg_rdata_c = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin : read_regs
    if (!Resetn) begin
      reg_rdata_q <= '0;
      sel_ram_q   <= 1'b0;
    end else begin
      reg_rdata_q <= reg_rdata_c;
      sel_ram_q   <= sel_ram_c;
    end
  end

  assign bus.DIN = sel_ram_q ? ram_q : reg_rdata_q;

endmodule
